// File: rtl/pid_pkg.sv
// pid_pkg: shared widths, stage/job enums and saturation helper
// for the PID arithmetic datapath.
package pid_pkg;

  localparam int EW_D    = 10;
  localparam int KW_D    = 9;
  localparam int AW_D    = 16;
  localparam int OW_D    = 16;
  localparam int SHIFT_D = 4;

  typedef enum logic [2:0] {
    ST_NONE,
    ST_S1,
    ST_S2,
    ST_S3,
    ST_S4
  } stage_e;

  typedef enum logic [1:0] {
    J_IDLE,
    J_LOAD,
    J_MUL,
    J_DONE
  } job_e;

  // Clamp a wide signed value into a w-bit signed range.
  function automatic logic signed [63:0] sat_w(
    input logic signed [63:0] x,
    input int                 w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/pid_shift_mult.sv
// pid_shift_mult: signed operand x unsigned gain, LSB-first
// shift-add, one gain bit per cycle (KW-cycle latency).
module pid_shift_mult #(
  parameter int AW = 16,
  parameter int KW = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             start_i,
  input  logic [AW-1:0]    a_i,
  input  logic [KW-1:0]    b_i,
  output logic [AW+KW-1:0] p_o,
  output logic             done_o
);

  localparam int PW = AW + KW;
  localparam int CW = $clog2(KW + 1);

  logic [PW-1:0] op_q;
  logic [KW-1:0] g_q;
  logic [PW-1:0] p_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          last;

  assign last   = (cnt_q == CW'(KW - 1));
  assign done_o = busy_q && last;
  assign p_o    = p_q;

  // Load on start, then add the shifted operand per set gain bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= '0;
      g_q    <= '0;
      p_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (clr_i) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      op_q   <= {{KW{a_i[AW-1]}}, a_i};
      g_q    <= b_i;
      p_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      p_q   <= p_q + (g_q[0] ? op_q : '0);
      op_q  <= op_q << 1;
      g_q   <= g_q >> 1;
      cnt_q <= cnt_q + 1'b1;
      if (last) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/pid_datapath.sv
// pid_datapath: P/I/D terms on one shared multiplier, output update,
// sample tick. Option: PID_ANTIWINDUP_EN holds acc while u is clamped.
module pid_datapath
  import pid_pkg::*;
#(
  parameter int EW         = EW_D,
  parameter int KW         = KW_D,
  parameter int AW         = AW_D,
  parameter int OW         = OW_D,
  parameter int SHIFT      = SHIFT_D,
  parameter int SAMPLE_DIV = 50000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rst1,
  input  logic          ena1,
  input  logic          ena2,
  input  logic          etapa2,
  input  logic          etapa3,
  input  logic          etapa4,
  input  logic [KW-1:0] kp,
  input  logic [KW-1:0] ki,
  input  logic [KW-1:0] kd,
  input  logic [EW-1:0] err,
  output logic          seg,
  output logic          tiempo,
  output logic [OW-1:0] u,
  output logic          sat
);

  localparam int PW = AW + KW;
  localparam int SW = PW + 2;
  localparam int DW = EW + 1;
  localparam int TW = $clog2(SAMPLE_DIV);

  stage_e code_d, code_q, hist_q, job_q;
  job_e   st_d, st_q;

  logic                 sampled_q, s1seg_q, ena2_q;
  logic signed [EW-1:0] err_s, e_q, ep_q;
  logic signed [AW-1:0] acc_q, anx_q, anx_d;
  logic signed [PW-1:0] p_q, i_q, d_q, mprod;
  logic signed [SW-1:0] sum_q, shf;
  logic signed [OW-1:0] u_q, u_nx;
  logic                 sat_q, clamp;
  logic [TW-1:0]        tcnt_q;
  logic                 tiempo_q;

  logic                 newc, s1_go, job_go, mstart, mdone, hold;
  logic [KW-1:0]        gain;
  logic [AW-1:0]        opnd;
  logic signed [DW-1:0] diff;
  logic signed [63:0]   acc_w, u_w;

  assign err_s  = err;
  assign newc   = (code_q != hist_q) && (code_q != ST_NONE);
  assign s1_go  = newc && (code_q == ST_S1) && (st_q == J_IDLE) && !rst1;
  assign job_go = newc && (code_q inside {ST_S2, ST_S3, ST_S4})
                  && (st_q == J_IDLE);
  assign seg    = (s1seg_q || (st_q == J_DONE)) && !rst1;
  assign tiempo = tiempo_q;
  assign u      = u_q;
  assign sat    = sat_q;

  // Decode the sequencer strobes into a stage code.
  always_comb begin
    code_d = ST_NONE;
    if (ena1) begin
      if (etapa2)         code_d = ST_S2;
      else if (etapa3)    code_d = ST_S3;
      else if (etapa4)    code_d = ST_S4;
      else if (!sampled_q) code_d = ST_S1;
    end
  end

  // Select gain/operand for the job and form the integrator update.
  always_comb begin
    diff  = DW'(e_q) - DW'(ep_q);
    acc_w = sat_w(64'(acc_q) + 64'(e_q), AW);
`ifdef PID_ANTIWINDUP_EN
    hold  = sat_q && (e_q[EW-1] == u_q[OW-1]);
`else
    hold  = 1'b0;
`endif
    anx_d = hold ? acc_q : AW'(acc_w);
    gain  = kp;
    opnd  = AW'(e_q);
    unique case (job_q)
      ST_S3: begin
        gain = ki;
        opnd = anx_d;
      end
      ST_S4: begin
        gain = kd;
        opnd = AW'(diff);
      end
      default: begin
        gain = kp;
        opnd = AW'(e_q);
      end
    endcase
  end

  // Scale and saturate the term sum for the output register.
  always_comb begin
    shf   = sum_q >>> SHIFT;
    u_w   = sat_w(64'(shf), OW);
    u_nx  = OW'(u_w);
    clamp = (u_w != 64'(shf));
  end

  // Job FSM next state: LOAD starts the multiplier, rst1 aborts.
  always_comb begin
    st_d   = st_q;
    mstart = 1'b0;
    unique case (st_q)
      J_IDLE:  if (job_go) st_d = J_LOAD;
      J_LOAD: begin
        mstart = 1'b1;
        st_d   = J_MUL;
      end
      J_MUL:   if (mdone) st_d = J_DONE;
      J_DONE:  st_d = J_IDLE;
      default: st_d = J_IDLE;
    endcase
    if (rst1) begin
      st_d   = J_IDLE;
      mstart = 1'b0;
    end
  end

  // Job FSM state register.
  always_ff @(posedge clk) begin
    if (rst) st_q <= J_IDLE;
    else     st_q <= st_d;
  end

  pid_shift_mult #(
    .AW(AW),
    .KW(KW)
  ) u_mult (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (rst1),
    .start_i(mstart),
    .a_i    (opnd),
    .b_i    (gain),
    .p_o    (mprod),
    .done_o (mdone)
  );

  // Stage tracking, term commits and the output update.
  always_ff @(posedge clk) begin
    if (rst) begin
      code_q    <= ST_NONE;
      hist_q    <= ST_NONE;
      job_q     <= ST_NONE;
      sampled_q <= 1'b0;
      s1seg_q   <= 1'b0;
      ena2_q    <= 1'b0;
      e_q       <= '0;
      ep_q      <= '0;
      acc_q     <= '0;
      anx_q     <= '0;
      p_q       <= '0;
      i_q       <= '0;
      d_q       <= '0;
      sum_q     <= '0;
      u_q       <= '0;
      sat_q     <= 1'b0;
    end else begin
      ena2_q <= ena2;
      if (ena2 && !ena2_q) begin
        u_q   <= u_nx;
        sat_q <= clamp;
      end
      if (rst1) begin
        code_q    <= ST_NONE;
        hist_q    <= ST_NONE;
        sampled_q <= 1'b0;
        s1seg_q   <= 1'b0;
        p_q       <= '0;
        i_q       <= '0;
        d_q       <= '0;
        sum_q     <= '0;
      end else begin
        code_q  <= code_d;
        hist_q  <= code_q;
        s1seg_q <= s1_go;
        if (s1_go) begin
          e_q       <= err_s;
          sampled_q <= 1'b1;
        end
        if (job_go) job_q <= code_q;
        if (st_q == J_LOAD) anx_q <= anx_d;
        if (st_q == J_DONE) begin
          unique case (job_q)
            ST_S2: p_q <= mprod;
            ST_S3: begin
              i_q   <= mprod;
              acc_q <= anx_q;
            end
            ST_S4: begin
              d_q   <= mprod;
              ep_q  <= e_q;
              sum_q <= SW'(p_q) + SW'(i_q) + SW'(mprod);
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Free-running sample period counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_q   <= '0;
      tiempo_q <= 1'b0;
    end else begin
      tiempo_q <= (tcnt_q == TW'(SAMPLE_DIV - 1));
      if (tcnt_q == TW'(SAMPLE_DIV - 1)) tcnt_q <= '0;
      else                               tcnt_q <= tcnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_pid_datapath.sv
// tb_pid_datapath: directed sequencer samples with hand-computed
// expected P/I/D sums, clamps, abort and sample tick.
module tb_pid_datapath;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst1 = 1'b0;
  logic       ena1 = 1'b0;
  logic       ena2 = 1'b0;
  logic       e2 = 1'b0;
  logic       e3 = 1'b0;
  logic       e4 = 1'b0;
  logic [8:0] kp = '0;
  logic [8:0] ki = '0;
  logic [8:0] kd = '0;
  logic [9:0] err = '0;
  logic       seg, tiempo, sat;
  logic [15:0] u;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pid_datapath #(
    .SAMPLE_DIV(8)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .rst1  (rst1),
    .ena1  (ena1),
    .ena2  (ena2),
    .etapa2(e2),
    .etapa3(e3),
    .etapa4(e4),
    .kp    (kp),
    .ki    (ki),
    .kd    (kd),
    .err   (err),
    .seg   (seg),
    .tiempo(tiempo),
    .u     (u),
    .sat   (sat)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic signed [39:0] obs,
                     input logic signed [39:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic wait_seg(input string tag, input int lat);
    int n = 0;
    bit got = 1'b0;
    while (!got && n < 40) begin
      tick();
      n++;
      if (seg === 1'b1) got = 1'b1;
    end
    chk({tag, "_lat"}, n, lat);
    tick();
    chk({tag, "_pulse"}, {39'd0, seg}, 0);
  endtask

  task automatic sample(input logic [9:0] e);
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    err  = e;
    ena1 = 1'b1;
    wait_seg("s1", 2);
    e2 = 1'b1;
    wait_seg("s2", 12);
    e2 = 1'b0;
    e3 = 1'b1;
    wait_seg("s3", 12);
    e3 = 1'b0;
    e4 = 1'b1;
    wait_seg("s4", 12);
    e4 = 1'b0;
    ena2 = 1'b1;
    tick();
    ena2 = 1'b0;
    ena1 = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int segs;
    repeat (3) tick();
    chk("rst_seg", {39'd0, seg}, 0);
    chk("rst_tiempo", {39'd0, tiempo}, 0);
    chk("rst_u", $signed(u), 0);
    chk("rst_sat", {39'd0, sat}, 0);
    chk("rst_acc", dut.acc_q, 0);

    rst = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      rst1 = (k == 12);
      tick();
      chk($sformatf("tiempo_c%0d", k), {39'd0, tiempo},
          (k % 8 == 0) ? 1 : 0);
    end
    rst1 = 1'b0;

    do_reset();
    kp = 9'd18;
    ki = 9'd7;
    kd = 9'd150;
    sample(10'sd10);
    chk("t1_sum", dut.sum_q, 1750);
    chk("t1_acc", dut.acc_q, 10);
    chk("t1_u", $signed(u), 109);
    chk("t1_sat", {39'd0, sat}, 0);

    sample(10'sd10);
    chk("t2_sum", dut.sum_q, 320);
    chk("t2_acc", dut.acc_q, 20);
    chk("t2_u", $signed(u), 20);

    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    err  = 10'sd10;
    ena1 = 1'b1;
    wait_seg("ab_s1", 2);
    e2 = 1'b1;
    wait_seg("ab_s2", 12);
    e2 = 1'b0;
    e3 = 1'b1;
    repeat (6) tick();
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    e3   = 1'b0;
    ena1 = 1'b0;
    segs = 0;
    repeat (15) begin
      tick();
      if (seg === 1'b1) segs++;
    end
    chk("ab_noseg", segs, 0);
    chk("ab_acc", dut.acc_q, 20);
    chk("ab_u", $signed(u), 20);

    do_reset();
    kp = 9'd511;
    ki = 9'd511;
    kd = 9'd511;
    sample(10'sd511);
    chk("sp_acc", dut.acc_q, 511);
    chk("sp_u", $signed(u), 32767);
    chk("sp_sat", {39'd0, sat}, 1);

    sample(10'sd5);
`ifdef PID_ANTIWINDUP_EN
    chk("aw_acc", dut.acc_q, 511);
    chk("aw_u", $signed(u), 319);
`else
    chk("aw_acc", dut.acc_q, 516);
    chk("aw_u", $signed(u), 479);
`endif
    chk("aw_sat", {39'd0, sat}, 0);

    do_reset();
    sample(-10'sd512);
    chk("sn_acc", dut.acc_q, -512);
    chk("sn_u", $signed(u), -32768);
    chk("sn_sat", {39'd0, sat}, 1);

    do_reset();
    kp = '0;
    ki = '0;
    kd = '0;
    repeat (64) sample(10'sd511);
    chk("ac_64", dut.acc_q, 32704);
    sample(10'sd511);
    chk("ac_65", dut.acc_q, 32767);
    sample(10'sd511);
    chk("ac_66", dut.acc_q, 32767);
    chk("ac_u", $signed(u), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
